cv32e40p_redundancy_manager: RTL and testbench

//  Sequential fault manager for N replicated execution units per op class (ALU, MULT, ...).

---
 rtl/cv32e40p_ft_pkg.sv | 27 ++
 rtl/cv32e40p_redundancy_manager_if.sv | 30 +++
 rtl/cv32e40p_replica_health.sv | 98 +++++++++
 rtl/cv32e40p_redundancy_manager.sv | 62 ++++++
 tb/tb_cv32e40p_redundancy_manager.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the EX-stage replica fault manager.
// Redundancy modes are ordered so that degradation only ever increases the value.
package cv32e40p_ft_pkg;

  typedef enum logic [1:0] {
    RED_TMR     = 2'b00,
    RED_DMR     = 2'b01,
    RED_SIMPLEX = 2'b10,
    RED_DEAD    = 2'b11
  } red_mode_e;

  localparam int unsigned CLASS_ALU  = 0;
  localparam int unsigned CLASS_MULT = 1;

  function automatic red_mode_e mode_for(input int unsigned healthy);
    red_mode_e m;
    m = RED_DEAD;
    unique case (1'b1)
      healthy >= 3: m = RED_TMR;
      healthy == 2: m = RED_DMR;
      healthy == 1: m = RED_SIMPLEX;
      default:      m = RED_DEAD;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cv32e40p_redundancy_manager_if.sv
// Voter/replica-pipe side bundle of the redundancy manager.
// master = core/voter side, slave = the manager itself.
interface cv32e40p_redundancy_manager_if #(
  parameter int unsigned N_REPLICA = 4,
  parameter int unsigned N_CLASS   = 2
);

  logic [N_CLASS-1:0]           op_done_i;
  logic [N_CLASS*N_REPLICA-1:0] mismatch_i;
  logic [N_CLASS-1:0]           busy_i;
  logic                         clear_i;
  logic [N_CLASS*N_REPLICA-1:0] active_o;
  logic [N_CLASS*2-1:0]         mode_o;
  logic [N_CLASS*N_REPLICA-1:0] perm_fault_o;
  logic                         fault_irq_o;
  logic [N_CLASS-1:0]           dead_o;

  modport master (
    output op_done_i, mismatch_i, busy_i, clear_i,
    input  active_o, mode_o, perm_fault_o,
    input  fault_irq_o, dead_o
  );

  modport slave (
    input  op_done_i, mismatch_i, busy_i, clear_i,
    output active_o, mode_o, perm_fault_o,
    output fault_irq_o, dead_o
  );

endinterface

// File: rtl/cv32e40p_replica_health.sv
// Per-class health tracker: leaky-bucket error counters, sticky faults,
// and the deferred active-replica / redundancy-mode selection.
module cv32e40p_replica_health
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned N_REPLICA   = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERM_THRESH = 8,
  parameter int unsigned DECAY_OPS   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_done,
  input  logic [N_REPLICA-1:0] mismatch,
  input  logic                 busy,
  input  logic                 clear,
  output logic [N_REPLICA-1:0] active,
  output red_mode_e            mode,
  output logic [N_REPLICA-1:0] perm_fault,
  output logic                 new_fault
);

  localparam int unsigned DW = $clog2(DECAY_OPS + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(PERM_THRESH);
  localparam logic [DW-1:0]    OPS_END = DW'(DECAY_OPS - 1);
  localparam logic [N_REPLICA-1:0] RST_ACT = N_REPLICA'(3'b111);

  logic [CNT_W-1:0]     cnt_q [N_REPLICA];
  logic [DW-1:0]        ops_q;
  logic [N_REPLICA-1:0] hit;
  logic [N_REPLICA-1:0] over;
  logic [N_REPLICA-1:0] tgt_active;
  red_mode_e            tgt_mode;
  int unsigned          n_ok;
  logic                 decay;

  always_comb begin
    hit   = mismatch & ~perm_fault & {N_REPLICA{op_done}};
    decay = op_done && !(|hit) && (ops_q == OPS_END);
    over  = '0;
    for (int r = 0; r < N_REPLICA; r++) begin
      over[r] = cnt_q[r] >= THRESH;
    end
  end

  // Lowest three healthy replicas are kept running, the rest are gated.
  always_comb begin
    n_ok       = 0;
    tgt_active = '0;
    for (int r = 0; r < N_REPLICA; r++) begin
      if (!perm_fault[r]) begin
        if (n_ok < 3) tgt_active[r] = 1'b1;
        n_ok = n_ok + 1;
      end
    end
    tgt_mode = mode_for(n_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N_REPLICA; r++) cnt_q[r] <= '0;
      ops_q      <= '0;
      perm_fault <= '0;
      new_fault  <= 1'b0;
      active     <= RST_ACT;
      mode       <= RED_TMR;
    end else if (clear) begin
      for (int r = 0; r < N_REPLICA; r++) cnt_q[r] <= '0;
      ops_q      <= '0;
      perm_fault <= '0;
      new_fault  <= 1'b0;
      active     <= RST_ACT;
      mode       <= RED_TMR;
    end else begin
      new_fault  <= |(over & ~perm_fault);
      perm_fault <= perm_fault | over;
      if (op_done) begin
        if (|hit || ops_q == OPS_END) ops_q <= '0;
        else ops_q <= ops_q + DW'(1);
      end
      for (int r = 0; r < N_REPLICA; r++) begin
        if (hit[r]) begin
          if (cnt_q[r] != CNT_MAX) cnt_q[r] <= cnt_q[r] + CNT_W'(1);
        end else if (decay && !perm_fault[r] && cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - CNT_W'(1);
        end
      end
      // Target follows sticky faults, so holding while busy loses nothing.
      if (!busy) begin
        active <= tgt_active;
        if (tgt_mode > mode) mode <= tgt_mode;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_redundancy_manager.sv
// EX-stage replica fault manager: one health tracker per op class,
// plus the shared permanent-fault interrupt pulse.
module cv32e40p_redundancy_manager
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned N_REPLICA   = 4,
  parameter int unsigned N_CLASS     = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERM_THRESH = 8,
  parameter int unsigned DECAY_OPS   = 16
) (
  input logic clk,
  input logic rst_n,
  cv32e40p_redundancy_manager_if.slave bus
);

  logic [N_CLASS*N_REPLICA-1:0] active_w;
  logic [N_CLASS*N_REPLICA-1:0] perm_w;
  logic [N_CLASS*2-1:0]         mode_w;
  logic [N_CLASS-1:0]           dead_w;
  logic [N_CLASS-1:0]           new_fault;
  logic                         irq_q;

  for (genvar c = 0; c < N_CLASS; c++) begin : g_class
    red_mode_e mode_c;

    cv32e40p_replica_health #(
      .N_REPLICA   (N_REPLICA),
      .CNT_W       (CNT_W),
      .PERM_THRESH (PERM_THRESH),
      .DECAY_OPS   (DECAY_OPS)
    ) u_health (
      .clk        (clk),
      .rst_n      (rst_n),
      .op_done    (bus.op_done_i[c]),
      .mismatch   (bus.mismatch_i[c*N_REPLICA +: N_REPLICA]),
      .busy       (bus.busy_i[c]),
      .clear      (bus.clear_i),
      .active     (active_w[c*N_REPLICA +: N_REPLICA]),
      .mode       (mode_c),
      .perm_fault (perm_w[c*N_REPLICA +: N_REPLICA]),
      .new_fault  (new_fault[c])
    );

    assign mode_w[2*c +: 2] = mode_c;
    assign dead_w[c]        = (mode_c == RED_DEAD);
  end

  // One pulse no matter how many replicas failed together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else if (bus.clear_i) irq_q <= 1'b0;
    else irq_q <= |new_fault;
  end

  assign bus.active_o     = active_w;
  assign bus.perm_fault_o = perm_w;
  assign bus.mode_o       = mode_w;
  assign bus.dead_o       = dead_w;
  assign bus.fault_irq_o  = irq_q;

endmodule

// File: tb/tb_cv32e40p_redundancy_manager.sv
// Bench for the replica fault manager: vector table, directed
// corner sequences and random traffic against a reference model.
module tb_cv32e40p_redundancy_manager;
  import cv32e40p_ft_pkg::*;

  localparam int NR    = 4;
  localparam int NC    = 2;
  localparam int PERM  = 8;
  localparam int DECAY = 16;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_redundancy_manager_if #(.N_REPLICA(NR), .N_CLASS(NC)) bus();

  cv32e40p_redundancy_manager #(
    .N_REPLICA(NR), .N_CLASS(NC), .CNT_W(4),
    .PERM_THRESH(PERM), .DECAY_OPS(DECAY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [1:0] od;
    logic [7:0] mm;
    logic [1:0] bz;
    logic       cl;
    logic [7:0] act;
    logic [3:0] mode;
    logic [7:0] perm;
    logic       irq;
  } vec_t;

  vec_t vec[$];
  int n_cmp = 0;
  int n_fail = 0;
  int irq_seen = 0;
  bit saw_dmr = 0;

  int       m_cnt[NC][NR];
  bit       m_perm[NC][NR];
  bit       o_perm[NC][NR];
  int       m_ops[NC];
  int       m_lvl[NC];
  logic [3:0] m_act[NC];
  bit       m_rose;
  bit       m_irq;

  function automatic vec_t mk(input logic [1:0] od, input logic [7:0] mm,
                              input logic [1:0] bz, input logic cl,
                              input logic [7:0] act, input logic [3:0] mode,
                              input logic [7:0] perm, input logic irq);
    vec_t v;
    v.od = od; v.mm = mm; v.bz = bz; v.cl = cl;
    v.act = act; v.mode = mode; v.perm = perm; v.irq = irq;
    return v;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        m_cnt[c][r] = 0;
        m_perm[c][r] = 0;
      end
      m_ops[c] = 0;
      m_lvl[c] = 0;
      m_act[c] = 4'b0111;
    end
    m_rose = 0;
    m_irq = 0;
  endtask

  // Model of one clock edge; every rule reads pre-edge state.
  task automatic m_step();
    int h;
    int lvl;
    bit any;
    bit mm_any;
    logic [3:0] pick;
    if (bus.clear_i) begin
      m_reset();
      return;
    end
    o_perm = m_perm;
    m_irq = m_rose;
    any = 0;
    for (int c = 0; c < NC; c++) begin
      h = 0;
      pick = '0;
      for (int r = 0; r < NR; r++) begin
        if (!o_perm[c][r]) begin
          if (h < 3) pick[r] = 1'b1;
          h++;
        end
      end
      if (!bus.busy_i[c]) begin
        m_act[c] = pick;
        lvl = 3 - (h < 3 ? h : 3);
        if (lvl > m_lvl[c]) m_lvl[c] = lvl;
      end
      for (int r = 0; r < NR; r++) begin
        if (!o_perm[c][r] && m_cnt[c][r] >= PERM) begin
          m_perm[c][r] = 1;
          any = 1;
        end
      end
      if (bus.op_done_i[c]) begin
        mm_any = 0;
        for (int r = 0; r < NR; r++) begin
          if (!o_perm[c][r] && bus.mismatch_i[c*NR+r]) begin
            mm_any = 1;
            if (m_cnt[c][r] < CMAX) m_cnt[c][r]++;
          end
        end
        if (mm_any) m_ops[c] = 0;
        else begin
          m_ops[c]++;
          if (m_ops[c] == DECAY) begin
            m_ops[c] = 0;
            for (int r = 0; r < NR; r++)
              if (!o_perm[c][r] && m_cnt[c][r] > 0) m_cnt[c][r]--;
          end
        end
      end
    end
    m_rose = any;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic check_model();
    logic [7:0] ep;
    logic [3:0] em;
    logic [1:0] ed;
    ep = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) ep[c*NR+r] = m_perm[c][r];
    em = {m_lvl[1][1:0], m_lvl[0][1:0]};
    ed = {m_lvl[1] == 3, m_lvl[0] == 3};
    chk("model_active", bus.active_o, {m_act[1], m_act[0]});
    chk("model_mode", bus.mode_o, em);
    chk("model_perm", bus.perm_fault_o, ep);
    chk("model_irq", bus.fault_irq_o, m_irq);
    chk("model_dead", bus.dead_o, ed);
  endtask

  task automatic step(input logic [1:0] od, input logic [7:0] mm,
                      input logic [1:0] bz, input logic cl);
    bus.op_done_i = od;
    bus.mismatch_i = mm;
    bus.busy_i = bz;
    bus.clear_i = cl;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_model();
    if (bus.fault_irq_o) irq_seen++;
    if (bus.mode_o[3:2] == 2'b01) saw_dmr = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 8'h00, 2'b00, 1'b0);
  endtask

  initial begin
    logic [1:0] od;
    logic [7:0] mm;
    logic [1:0] bz;
    int bad0;
    int bad1;

    // ALU replica 1 fails, idle and then busy-deferred variants.
    for (int i = 0; i < 8; i++)
      vec.push_back(mk(2'b01, 8'h02, 2'b00, 0, 8'h77, 4'h0, 8'h00, 0));
    vec.push_back(mk(2'b00, 8'h00, 2'b00, 0, 8'h77, 4'h0, 8'h02, 0));
    vec.push_back(mk(2'b00, 8'h00, 2'b00, 0, 8'h7D, 4'h0, 8'h02, 1));
    vec.push_back(mk(2'b00, 8'h00, 2'b00, 0, 8'h7D, 4'h0, 8'h02, 0));
    vec.push_back(mk(2'b00, 8'h00, 2'b00, 1, 8'h77, 4'h0, 8'h00, 0));
    vec.push_back(mk(2'b00, 8'hFF, 2'b00, 0, 8'h77, 4'h0, 8'h00, 0));
    vec.push_back(mk(2'b00, 8'hFF, 2'b00, 0, 8'h77, 4'h0, 8'h00, 0));
    for (int i = 0; i < 8; i++)
      vec.push_back(mk(2'b01, 8'h02, 2'b00, 0, 8'h77, 4'h0, 8'h00, 0));
    vec.push_back(mk(2'b00, 8'h00, 2'b01, 0, 8'h77, 4'h0, 8'h02, 0));
    vec.push_back(mk(2'b00, 8'h00, 2'b01, 0, 8'h77, 4'h0, 8'h02, 1));
    for (int i = 0; i < 3; i++)
      vec.push_back(mk(2'b00, 8'h00, 2'b01, 0, 8'h77, 4'h0, 8'h02, 0));
    vec.push_back(mk(2'b00, 8'h00, 2'b00, 0, 8'h7D, 4'h0, 8'h02, 0));

    bus.op_done_i = '0;
    bus.mismatch_i = '0;
    bus.busy_i = '0;
    bus.clear_i = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_active", bus.active_o, 8'h77);
    chk("rst_mode", bus.mode_o, 4'h0);
    chk("rst_perm", bus.perm_fault_o, 8'h00);
    chk("rst_irq", bus.fault_irq_o, 1'b0);
    chk("rst_dead", bus.dead_o, 2'b00);
    rst_n = 1'b1;

    foreach (vec[i]) begin
      step(vec[i].od, vec[i].mm, vec[i].bz, vec[i].cl);
      chk($sformatf("vec%0d_active", i), bus.active_o, vec[i].act);
      chk($sformatf("vec%0d_mode", i), bus.mode_o, vec[i].mode);
      chk($sformatf("vec%0d_perm", i), bus.perm_fault_o, vec[i].perm);
      chk($sformatf("vec%0d_irq", i), bus.fault_irq_o, vec[i].irq);
    end

    // Clean traffic keeps full TMR.
    step(2'b00, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 100; i++)
      step(2'($urandom_range(1, 3)), 8'h00, 2'($urandom), 1'b0);
    idle(2);
    chk("clean_active", bus.active_o, 8'h77);
    chk("clean_mode", bus.mode_o, 4'h0);
    chk("clean_perm", bus.perm_fault_o, 8'h00);

    // 7 errors then 16 clean ops leave 6: one more error is safe, two is fatal.
    step(2'b00, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++) step(2'b01, 8'h04, 2'b00, 1'b0);
    for (int i = 0; i < 16; i++) step(2'b01, 8'h00, 2'b00, 1'b0);
    step(2'b01, 8'h04, 2'b00, 1'b0);
    idle(2);
    chk("decay16_no_fault", bus.perm_fault_o, 8'h00);
    step(2'b01, 8'h04, 2'b00, 1'b0);
    idle(2);
    chk("decay16_fault", bus.perm_fault_o, 8'h04);

    // After 32 clean ops the count is 5: two more errors safe, three fatal.
    step(2'b00, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++) step(2'b01, 8'h04, 2'b00, 1'b0);
    for (int i = 0; i < 32; i++) step(2'b01, 8'h00, 2'b00, 1'b0);
    step(2'b01, 8'h04, 2'b00, 1'b0);
    step(2'b01, 8'h04, 2'b00, 1'b0);
    idle(2);
    chk("decay32_no_fault", bus.perm_fault_o, 8'h00);
    step(2'b01, 8'h04, 2'b00, 1'b0);
    idle(2);
    chk("decay32_fault", bus.perm_fault_o, 8'h04);

    // MULT replicas 0..2 fail together, then replica 3.
    step(2'b00, 8'h00, 2'b00, 1'b1);
    irq_seen = 0;
    saw_dmr = 0;
    for (int i = 0; i < 8; i++) step(2'b10, 8'h70, 2'b00, 1'b0);
    idle(3);
    chk("triple_active", bus.active_o[7:4], 4'b1000);
    chk("triple_mode", bus.mode_o[3:2], RED_SIMPLEX);
    chk("triple_irq_count", irq_seen, 1);
    chk("triple_skip_dmr", saw_dmr, 1'b0);
    irq_seen = 0;
    for (int i = 0; i < 8; i++) step(2'b10, 8'h80, 2'b00, 1'b0);
    idle(3);
    chk("dead_mode", bus.mode_o[3:2], RED_DEAD);
    chk("dead_flag", bus.dead_o, 2'b10);
    chk("dead_active", bus.active_o[7:4], 4'b0000);
    chk("dead_irq_count", irq_seen, 1);

    // Clear wins even while busy.
    step(2'b11, 8'hFF, 2'b11, 1'b1);
    chk("clear_active", bus.active_o, 8'h77);
    chk("clear_mode", bus.mode_o, 4'h0);
    chk("clear_perm", bus.perm_fault_o, 8'h00);
    chk("clear_dead", bus.dead_o, 2'b00);

    // Random traffic with one misbehaving replica per class.
    bad0 = 0;
    bad1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        bad0 = $urandom_range(0, NR - 1);
        bad1 = $urandom_range(0, NR - 1);
      end
      od = '0;
      mm = '0;
      for (int c = 0; c < NC; c++) od[c] = ($urandom_range(0, 99) < 70);
      for (int r = 0; r < NR; r++) begin
        mm[r]    = ($urandom_range(0, 99) < (r == bad0 ? 50 : 3));
        mm[NR+r] = ($urandom_range(0, 99) < (r == bad1 ? 50 : 3));
      end
      for (int c = 0; c < NC; c++) bz[c] = ($urandom_range(0, 99) < 30);
      step(od, mm, bz, (i % 600 == 599) || ($urandom_range(0, 399) == 0));
    end

    // Async reset in the middle of a busy, faulting stretch.
    for (int i = 0; i < 10; i++) step(2'b11, 8'h11, 2'b11, 1'b0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_active", bus.active_o, 8'h77);
    chk("arst_mode", bus.mode_o, 4'h0);
    chk("arst_perm", bus.perm_fault_o, 8'h00);
    chk("arst_irq", bus.fault_irq_o, 1'b0);
    bus.busy_i = 2'b00;
    bus.op_done_i = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("arst_after_active", bus.active_o, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
